// File: rtl/vga_timing_pkg.sv
// Shared timing types and helpers for the VGA raster generator.
// An axis is described by its four segment lengths in pixel or line units.
package vga_timing_pkg;

  typedef struct packed {
    int unsigned visible;
    int unsigned front;
    int unsigned sync;
    int unsigned back;
  } timing_t;

  localparam timing_t VGA_640X480_H = '{visible: 640, front: 16, sync: 96, back: 48};
  localparam timing_t VGA_640X480_V = '{visible: 480, front: 10, sync: 2, back: 33};

  function automatic int unsigned total_len(timing_t t);
    return t.visible + t.front + t.sync + t.back;
  endfunction

  function automatic int unsigned sync_start(timing_t t);
    return t.visible + t.front;
  endfunction

  function automatic int unsigned sync_end(timing_t t);
    return t.visible + t.front + t.sync;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus visible/sync region decode
// of the current count. Used once per line (h) and once per frame (v).
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter timing_t     LEN = VGA_640X480_H,
  parameter int unsigned W   = 10
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         adv_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o,
  output logic         visible_o,
  output logic         sync_o
);

  localparam int unsigned       TOTAL     = total_len(LEN);
  localparam longint unsigned   MAX_TOTAL = 64'd1 << W;

  if (LEN.visible == 0 || LEN.front == 0 || LEN.sync == 0 || LEN.back == 0) begin : g_len_zero
    $error("vga_axis_counter: every segment length must be non-zero");
  end

  if (64'(TOTAL) > MAX_TOTAL) begin : g_len_wide
    $error("vga_axis_counter: axis total does not fit in the coordinate width");
  end

  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] VIS_END = W'(LEN.visible);
  localparam logic [W-1:0] SYNC_LO = W'(sync_start(LEN));
  localparam logic [W-1:0] SYNC_HI = W'(sync_end(LEN));

  logic [W-1:0] count_q, count_d;

  assign wrap_o    = (count_q == LAST);
  assign visible_o = (count_q < VIS_END);
  assign sync_o    = (count_q >= SYNC_LO) && (count_q < SYNC_HI);
  assign count_o   = count_q;

  always_comb begin
    count_d = count_q;
    if (adv_i) begin
      count_d = wrap_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel clock-enable.
// Every output is registered from the same (h,v) decode, so all outputs describe one pixel.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE         = 640,
  parameter int unsigned H_FRONT           = 16,
  parameter int unsigned H_SYNC            = 96,
  parameter int unsigned H_BACK            = 48,
  parameter int unsigned V_VISIBLE         = 480,
  parameter int unsigned V_FRONT           = 10,
  parameter int unsigned V_SYNC            = 2,
  parameter int unsigned V_BACK            = 33,
  parameter bit          HSYNC_ACTIVE_HIGH = 1'b0,
  parameter bit          VSYNC_ACTIVE_HIGH = 1'b0,
  parameter int unsigned COORD_W           = 10,
  parameter int unsigned FRAME_W           = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               pix_en_i,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               visible_o,
  output logic [COORD_W-1:0] position_x_o,
  output logic [COORD_W-1:0] position_y_o,
  output logic               line_start_o,
  output logic               frame_start_o,
  output logic [FRAME_W-1:0] frame_count_o
);

  localparam timing_t H_LEN = '{visible: H_VISIBLE, front: H_FRONT, sync: H_SYNC, back: H_BACK};
  localparam timing_t V_LEN = '{visible: V_VISIBLE, front: V_FRONT, sync: V_SYNC, back: V_BACK};
  localparam logic    HS_ON = HSYNC_ACTIVE_HIGH;
  localparam logic    VS_ON = VSYNC_ACTIVE_HIGH;

  logic [COORD_W-1:0] h_count, v_count;
  logic               h_wrap, v_wrap, h_vis, v_vis, h_sync, v_sync;

  vga_axis_counter #(.LEN(H_LEN), .W(COORD_W)) u_h_axis (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .adv_i     (pix_en_i),
    .count_o   (h_count),
    .wrap_o    (h_wrap),
    .visible_o (h_vis),
    .sync_o    (h_sync)
  );

  vga_axis_counter #(.LEN(V_LEN), .W(COORD_W)) u_v_axis (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .adv_i     (pix_en_i & h_wrap),
    .count_o   (v_count),
    .wrap_o    (v_wrap),
    .visible_o (v_vis),
    .sync_o    (v_sync)
  );

  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               visible_q, visible_d;
  logic [COORD_W-1:0] pos_x_q, pos_x_d;
  logic [COORD_W-1:0] pos_y_q, pos_y_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;
  logic [FRAME_W-1:0] frame_count_q, frame_count_d;
  // Completed frames so far; copied into frame_count_q when the next (0,0) is decoded.
  logic [FRAME_W-1:0] frames_done_q, frames_done_d;

  always_comb begin
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    visible_d     = visible_q;
    pos_x_d       = pos_x_q;
    pos_y_d       = pos_y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_count_d = frame_count_q;
    frames_done_d = frames_done_q;
    if (pix_en_i) begin
      hsync_d       = h_sync ? HS_ON : ~HS_ON;
      vsync_d       = v_sync ? VS_ON : ~VS_ON;
      visible_d     = h_vis & v_vis;
      pos_x_d       = h_count;
      pos_y_d       = v_count;
      line_start_d  = (h_count == '0);
      frame_start_d = (h_count == '0) && (v_count == '0);
      frame_count_d = frames_done_q;
      if (h_wrap && v_wrap) begin
        frames_done_d = frames_done_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hsync_q       <= ~HS_ON;
      vsync_q       <= ~VS_ON;
      visible_q     <= 1'b0;
      pos_x_q       <= '0;
      pos_y_q       <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
      frames_done_q <= '0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      visible_q     <= visible_d;
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
      frames_done_q <= frames_done_d;
    end
  end

  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign visible_o     = visible_q;
  assign position_x_o  = pos_x_q;
  assign position_y_o  = pos_y_q;
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;
  assign frame_count_o = frame_count_q;

endmodule
